// File: rtl/fifo_pkt_framer.sv
// Packet framer: pops a show-ahead FIFO and streams PKT_LEN payload words per packet,
// followed by a {seq, len} trailer word and a 16-bit additive checksum word.
module fifo_pkt_framer #(
   parameter int WIDTH   = 16,
   parameter int PKT_LEN = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [15:0]      pkt_cnt
);

   typedef enum logic [1:0] {WAIT_RST, PAYLOAD, TRAILER, CSUM} state_t;

   localparam logic [7:0]  LEN_FULL = 8'(PKT_LEN);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t           state;
   logic [7:0]       seq;
   logic [7:0]       len;
   logic [15:0]      sum;
   logic [15:0]      tmo;
   logic             out_free;
   logic             pop;
   logic             timeout_hit;
   logic [WIDTH-1:0] trailer_word;
   logic [WIDTH-1:0] csum_word;

   // The pop strobe is gated by reset_p so the FIFO never advances during reset.
   always_comb begin
      out_free           = ~m_valid | m_ready;
      pop                = (state == PAYLOAD) & ~fifo_empty & out_free & ~reset_p;
      fifo_rd            = pop;
      timeout_hit        = (state == PAYLOAD) && (len != 8'd0) && (tmo == TMO_LAST) && !pop;
      trailer_word       = '0;
      trailer_word[15:0] = {seq, len};
      csum_word          = '0;
      csum_word[15:0]    = sum;
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state   <= WAIT_RST;
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         pkt_cnt <= 16'd0;
         seq     <= 8'd0;
         len     <= 8'd0;
         sum     <= 16'd0;
         tmo     <= 16'd0;
      end else begin
         // An accepted word drops valid; any load below overrides it, so there is no bubble.
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
               pkt_cnt <= pkt_cnt + 16'd1;
            end
         end
         case (state)
            WAIT_RST: begin
               state <= PAYLOAD;
            end
            PAYLOAD: begin
               if (pop) begin
                  m_data  <= fifo_data;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  len     <= len + 8'd1;
                  sum     <= sum + fifo_data[15:0];
                  tmo     <= 16'd0;
                  if (len + 8'd1 == LEN_FULL) begin
                     state <= TRAILER;
                  end
               end else if (len == 8'd0) begin
                  tmo <= 16'd0;
               end else begin
                  if (fifo_empty) begin
                     tmo <= tmo + 16'd1;
                  end
                  if (timeout_hit) begin
                     state <= TRAILER;
                  end
               end
            end
            TRAILER: begin
               if (out_free) begin
                  m_data  <= trailer_word;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  state   <= CSUM;
               end
            end
            CSUM: begin
               if (out_free) begin
                  m_data  <= csum_word;
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
                  len     <= 8'd0;
                  sum     <= 16'd0;
                  tmo     <= 16'd0;
                  seq     <= seq + 8'd1;
                  state   <= PAYLOAD;
               end
            end
            default: begin
               state <= WAIT_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Scoreboard bench for fifo_pkt_framer: a queue models the show-ahead FIFO and a
// negedge monitor compares every accepted output word against expected words.
module tb_fifo_pkt_framer;

   localparam int WIDTH   = 16;
   localparam int PKT_LEN = 4;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset_p;
   logic [WIDTH-1:0]  fifo_data;
   logic              fifo_empty;
   logic              fifo_rd;
   logic [WIDTH-1:0]  m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic [15:0]       pkt_cnt;

   logic [15:0] fq[$];
   logic [16:0] exp_q[$];
   logic [16:0] mon_exp;
   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   fifo_pkt_framer #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset_p    (reset_p),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .pkt_cnt    (pkt_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic refreshFifo();
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? 16'h0000 : fq[0];
   endtask

   // One clock: sample the pop strobe mid-cycle, then update the FIFO model after the edge.
   task automatic tick();
      logic rd;
      logic rst;
      @(negedge clk);
      rd  = fifo_rd;
      rst = reset_p;
      @(posedge clk);
      #1;
      if (rst) fq.delete();
      else if (rd && fq.size() != 0) void'(fq.pop_front());
      refreshFifo();
   endtask

   task automatic pushWord(input logic [15:0] w);
      fq.push_back(w);
      exp_q.push_back({1'b0, w});
      refreshFifo();
   endtask

   task automatic expectTail(input logic [15:0] trailer, input logic [15:0] csum);
      exp_q.push_back({1'b0, trailer});
      exp_q.push_back({1'b1, csum});
   endtask

   task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input logic [15:0] w3, input logic [15:0] trailer, input logic [15:0] csum);
      pushWord(w0);
      pushWord(w1);
      pushWord(w2);
      pushWord(w3);
      expectTail(trailer, csum);
   endtask

   task automatic drain(input int limit, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      checkOutput("drain_left", exp_q.size(), 0);
   endtask

   task automatic doReset();
      reset_p = 1'b1;
      tick();
      tick();
      checkOutput("rst_m_valid", {31'b0, m_valid}, 0);
      checkOutput("rst_m_last", {31'b0, m_last}, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_pkt_cnt", pkt_cnt, 0);
      checkOutput("rst_fifo_rd", {31'b0, fifo_rd}, 0);
      reset_p = 1'b0;
   endtask

   always @(negedge clk) begin
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_word: got 0x%0h last %0b, expected no word", m_data, m_last);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("stream", {15'b0, m_last, m_data}, {15'b0, mon_exp});
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      reset_p = 1'b1;
      m_ready = 1'b1;
      refreshFifo();

      $display("[TB] full packet after reset");
      doReset();
      applyStimulus(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 16'h000A);
      #1;
      checkOutput("rd_in_wait_rst", {31'b0, fifo_rd}, 0);
      drain(40, n);
      checkOutput("pkt_cnt_full", pkt_cnt, 1);

      $display("[TB] back-pressure");
      applyStimulus(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0104, 16'h000A);
      n = 0;
      while (!(m_valid === 1'b1 && m_data == 16'h0002) && n < 20) begin
         tick();
         n++;
      end
      checkOutput("bp_second_word", m_data, 16'h0002);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("bp_data", m_data, 16'h0002);
         checkOutput("bp_valid", {31'b0, m_valid}, 1);
         checkOutput("bp_fifo_rd", {31'b0, fifo_rd}, 0);
         tick();
      end
      m_ready = 1'b1;
      drain(40, n);
      checkOutput("pkt_cnt_bp", pkt_cnt, 2);

      $display("[TB] timeout closes partial packet");
      doReset();
      pushWord(16'h1111);
      pushWord(16'h2222);
      expectTail(16'h0002, 16'h3333);
      #1;
      checkOutput("rd_release_cycle", {31'b0, fifo_rd}, 0);
      n = 0;
      while (fq.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      n = 0;
      while (!(m_valid === 1'b1 && m_data == 16'h0002) && n < 40) begin
         tick();
         n++;
      end
      checkOutput("tmo_latency", n, TIMEOUT + 1);
      drain(20, n);
      checkOutput("pkt_cnt_tmo", pkt_cnt, 1);

      $display("[TB] checksum wrap, seq 1");
      applyStimulus(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0104, 16'h0001);
      drain(40, n);
      checkOutput("pkt_cnt_wrap", pkt_cnt, 2);

      $display("[TB] sequence wrap over 257 packets");
      doReset();
      for (int p = 0; p < 257; p++) begin
         applyStimulus(16'h0010, 16'h0020, 16'h0030, 16'h0040, {8'(p), 8'h04}, 16'h00A0);
      end
      drain(3000, n);
      checkOutput("throughput_cycles", n, 257 * (PKT_LEN + 2) + 2);
      checkOutput("pkt_cnt_257", pkt_cnt, 257);

      $display("[TB] reset mid-packet");
      pushWord(16'h0100);
      pushWord(16'h0200);
      drain(20, n);
      reset_p = 1'b1;
      fq.push_back(16'h0300);
      fq.push_back(16'h0400);
      refreshFifo();
      #1;
      checkOutput("rd_during_reset", {31'b0, fifo_rd}, 0);
      tick();
      checkOutput("mid_rst_valid", {31'b0, m_valid}, 0);
      checkOutput("mid_rst_pkt_cnt", pkt_cnt, 0);
      reset_p = 1'b0;
      applyStimulus(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0004, 16'h00AA);
      #1;
      checkOutput("rd_after_mid_rst", {31'b0, fifo_rd}, 0);
      drain(40, n);
      for (int i = 0; i < TIMEOUT + 4; i++) tick();
      checkOutput("pkt_cnt_after_rst", pkt_cnt, 1);
      checkOutput("final_idle_valid", {31'b0, m_valid}, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
